// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int REG_ZERO = 0;

    // Wide enough for any legal packed port vector (4 ports x 64 bits).
    localparam int PORT_VEC_W = 256;
    typedef logic [PORT_VEC_W-1:0] port_vec_t;

    // Field idx of a packed vector made of width-bit fields, right-aligned.
    function automatic port_vec_t port_slice(input port_vec_t vec, input int idx, input int width);
        port_vec_t mask;
        mask = (port_vec_t'(1) << width) - port_vec_t'(1);
        return (vec >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by claims, cleared by writes,
// looked up combinationally by every read port.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ready,
    input  logic              i_rd_we,
    input  logic [AW-1:0]     i_rd_addr,
    input  logic              i_claim_valid,
    input  logic [AW-1:0]     i_claim_addr,
    input  logic [NRD*AW-1:0] i_rs_addr,
    output logic [NRD-1:0]    o_rs_busy
);

    logic [NREGS-1:0] busy;
    logic [AW-1:0]    port_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy <= '0;
        end else if (i_ready) begin
            if (i_rd_we && i_rd_addr != AW'(REG_ZERO))
                busy[i_rd_addr] <= 1'b0;
            // NOTE: the later non-blocking assignment wins, which gives the claim priority over a
            // same-cycle write to the same register (the claim belongs to a younger instruction).
            if (i_claim_valid && i_claim_addr != AW'(REG_ZERO))
                busy[i_claim_addr] <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
        o_rs_busy = '0;
        port_addr = '0;
        for (int k = 0; k < NRD; k++) begin
            port_addr = AW'(port_slice(port_vec_t'(i_rs_addr), k, AW));
            if (i_ready && port_addr != AW'(REG_ZERO)) begin
                if (BYPASS != 0 && i_rd_we && i_rd_addr == port_addr)
                    o_rs_busy[k] = 1'b0;
                else
                    o_rs_busy[k] = busy[port_addr];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with post-reset clear sweep,
// optional write-to-read bypass and a pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rd_we,
    input  logic [AW-1:0]       i_rd_addr,
    input  logic [XLEN-1:0]     i_rd_data,
    input  logic                i_claim_valid,
    input  logic [AW-1:0]       i_claim_addr,
    input  logic [NRD*AW-1:0]   i_rs_addr,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]      o_rs_busy,
    output logic                o_ready
);

    rf_state_t       state;
    logic [AW-1:0]   cnt;
    logic            ready;
    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   port_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= RF_CLEAR;
            cnt   <= AW'(1);
        end else if (state == RF_CLEAR) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(NREGS - 1))
                state <= RF_RUN;
        end
    end

    assign ready   = (state == RF_RUN);
    assign o_ready = ready;

    // NOTE: storage deliberately has no reset; the clear sweep zeroes it one register per cycle,
    // which keeps the array free of a reset network and mappable onto plain flops or RAM.
    always_ff @(posedge i_clk) begin
        if (state == RF_CLEAR)
            regs[cnt] <= '0;
        else if (i_rd_we && i_rd_addr != AW'(REG_ZERO))
            regs[i_rd_addr] <= i_rd_data;
    end

    always_comb begin
        o_rs_data = '0;
        port_addr = '0;
        for (int k = 0; k < NRD; k++) begin
            port_addr = AW'(port_slice(port_vec_t'(i_rs_addr), k, AW));
            if (ready && port_addr != AW'(REG_ZERO)) begin
                if (BYPASS != 0 && i_rd_we && i_rd_addr == port_addr)
                    o_rs_data[k*XLEN +: XLEN] = i_rd_data;
                else
                    o_rs_data[k*XLEN +: XLEN] = regs[port_addr];
            end
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_ready       (ready),
        .i_rd_we       (i_rd_we),
        .i_rd_addr     (i_rd_addr),
        .i_claim_valid (i_claim_valid),
        .i_claim_addr  (i_claim_addr),
        .i_rs_addr     (i_rs_addr),
        .o_rs_busy     (o_rs_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and are compared
// against one behavioural model of register contents, busy flags and sweep progress.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst;
    logic                rd_we;
    logic [AW-1:0]       rd_addr;
    logic [XLEN-1:0]     rd_data;
    logic                claim_valid;
    logic [AW-1:0]       claim_addr;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data_b, rs_data_n;
    logic [NRD-1:0]      rs_busy_b, rs_busy_n;
    logic                ready_b, ready_n;

    int compared   = 0;
    int mismatched = 0;

    // Reference model
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              m_sweep;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rd_we(rd_we), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
        .i_claim_valid(claim_valid), .i_claim_addr(claim_addr), .i_rs_addr(rs_addr),
        .o_rs_data(rs_data_b), .o_rs_busy(rs_busy_b), .o_ready(ready_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_rd_we(rd_we), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
        .i_claim_valid(claim_valid), .i_claim_addr(claim_addr), .i_rs_addr(rs_addr),
        .o_rs_data(rs_data_n), .o_rs_busy(rs_busy_n), .o_ready(ready_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return !rst && (m_sweep == NREGS - 1);
    endfunction

    task automatic expect_port(input bit byp, input logic [AW-1:0] a,
                               output logic [XLEN-1:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (m_ready() && a != 0) begin
            if (byp && rd_we && rd_addr == a) begin
                d = rd_data;
            end else begin
                d = m_regs[a];
                b = m_busy[a];
            end
        end
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            m_sweep = 0;
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input int wa, input logic [XLEN-1:0] wd,
                         input logic cv, input int ca);
        rd_we       = we;
        rd_addr     = AW'(wa);
        rd_data     = wd;
        claim_valid = cv;
        claim_addr  = AW'(ca);
    endtask

    task automatic set_port(input int k, input int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    // Advance one edge; the model applies the rules to the inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (m_sweep < NREGS - 1) begin
                m_sweep++;
                m_regs[m_sweep] = '0;
            end else begin
                if (rd_we && rd_addr != 0) begin
                    m_regs[rd_addr] = rd_data;
                    m_busy[rd_addr] = 1'b0;
                end
                if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic check_ports();
        logic [XLEN-1:0] d;
        logic            b;
        logic [AW-1:0]   a;
        #1;
        check("ready_byp", 64'(ready_b), 64'(m_ready()));
        check("ready_nobyp", 64'(ready_n), 64'(m_ready()));
        for (int k = 0; k < NRD; k++) begin
            a = rs_addr[k*AW +: AW];
            expect_port(1'b1, a, d, b);
            check($sformatf("byp_data_p%0d_x%0d", k, a), 64'(rs_data_b[k*XLEN +: XLEN]), 64'(d));
            check($sformatf("byp_busy_p%0d_x%0d", k, a), 64'(rs_busy_b[k]), 64'(b));
            expect_port(1'b0, a, d, b);
            check($sformatf("nobyp_data_p%0d_x%0d", k, a), 64'(rs_data_n[k*XLEN +: XLEN]), 64'(d));
            check($sformatf("nobyp_busy_p%0d_x%0d", k, a), 64'(rs_busy_n[k]), 64'(b));
        end
    endtask

    task automatic sweep(input int poke_at);
        for (int e = 1; e <= NREGS - 1; e++) begin
            if (e == poke_at) drive(1'b1, 3, 32'h55, 1'b1, 3);
            else              drive(1'b0, 0, '0, 1'b0, 0);
            tick();
            check($sformatf("sweep_ready_e%0d", e), 64'(ready_b), 64'(e == NREGS - 1));
            check($sformatf("sweep_ready_n_e%0d", e), 64'(ready_n), 64'(e == NREGS - 1));
        end
        drive(1'b0, 0, '0, 1'b0, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < NREGS; a += NRD) begin
            for (int k = 0; k < NRD; k++) set_port(k, (a + k) % NREGS);
            check_ports();
        end
    endtask

    initial begin
        rs_addr = '0;
        drive(1'b0, 0, '0, 1'b0, 0);
        set_rst(1'b1);
        #1;
        check("reset_ready", 64'(ready_b), 64'd0);
        check("reset_data", 64'(rs_data_b[XLEN-1:0]), 64'd0);

        // Reset held 3 cycles, then sweep with an ignored write/claim to x3
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ports();
        end
        set_rst(1'b0);
        sweep(5);
        read_all();
        set_port(0, 3);
        #1;
        check("x3_after_clear", 64'(rs_data_b[XLEN-1:0]), 64'd0);
        check("x3_busy_after_clear", 64'(rs_busy_b[0]), 64'd0);

        // Write x5 with bypass
        set_port(0, 5); set_port(1, 5); set_port(2, 0);
        drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0);
        check_ports();
        check("x5_bypass_same", 64'(rs_data_b[XLEN-1:0]), 64'hDEADBEEF);
        check("x5_nobypass_same", 64'(rs_data_n[XLEN-1:0]), 64'd0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0);
        check_ports();
        check("x5_nobypass_next", 64'(rs_data_n[XLEN-1:0]), 64'hDEADBEEF);

        // x0 hardwiring
        for (int k = 0; k < NRD; k++) set_port(k, 0);
        drive(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0);
        check_ports();
        tick();
        drive(1'b0, 0, '0, 1'b0, 0);
        check_ports();
        check("x0_data", 64'(rs_data_b), 64'd0);
        check("x0_busy", 64'(rs_busy_b | rs_busy_n), 64'd0);

        // Scoreboard collision on x7
        for (int k = 0; k < NRD; k++) set_port(k, 7);
        drive(1'b0, 0, '0, 1'b1, 7);
        check_ports();
        check("x7_claim_same_cycle", 64'(rs_busy_b[0]), 64'd0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0);
        check_ports();
        check("x7_busy_n1", 64'(rs_busy_b[0]), 64'd1);
        tick();
        drive(1'b1, 7, 32'h12, 1'b1, 7);
        check_ports();
        tick();
        drive(1'b0, 0, '0, 1'b0, 0);
        check_ports();
        check("x7_data_after", 64'(rs_data_n[XLEN-1:0]), 64'h12);
        check("x7_busy_after", 64'(rs_busy_n[0]), 64'd1);
        check("x7_ports_agree", 64'(rs_data_b[2*XLEN +: XLEN]), 64'h12);

        // Randomised traffic, addresses biased toward a few low registers for collisions
        for (int i = 0; i < 400; i++) begin
            int wa, ca;
            wa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NREGS - 1));
            ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NREGS - 1));
            drive(1'($urandom), wa, $urandom, 1'($urandom), ca);
            for (int k = 0; k < NRD; k++)
                set_port(k, ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, NREGS - 1)));
            check_ports();
            tick();
        end
        drive(1'b0, 0, '0, 1'b0, 0);
        read_all();

        // Mid-run reset
        set_port(0, 9);
        drive(1'b1, 9, 32'hA5, 1'b1, 11);
        tick();
        drive(1'b0, 0, '0, 1'b0, 0);
        check_ports();
        check("x9_written", 64'(rs_data_b[XLEN-1:0]), 64'hA5);
        set_rst(1'b1);
        #1;
        check("midrun_ready_drop", 64'(ready_b), 64'd0);
        check("midrun_ready_drop_n", 64'(ready_n), 64'd0);
        tick();
        set_rst(1'b0);
        sweep(0);
        read_all();
        set_port(0, 9);
        #1;
        check("x9_after_reset", 64'(rs_data_b[XLEN-1:0]), 64'd0);
        check("x11_busy_after_reset", 64'(rs_busy_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
